fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-stage forwarding unit.
- Sits in the ID stage of the pipelined datapath. It tracks in-flight destination tags internally, so the pipeline does not need to feed back EX/MEM and MEM/WB register numbers.
- Per cycle it produces:
  - a registered forwarding select for every source operand of the instruction entering EX;
  - a load-use stall, with a configurable stall length.
- Also handles swap-mode operands and EX flushes, and keeps a saturating stall statistic.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_src_sel.sv | 36 +++
 rtl/fwd_hazard_unit.sv | 114 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings, tag record type and match helper for the ID-stage forwarding/hazard unit.
package fwd_pkg;

  localparam logic [1:0] FWD_SWAP  = 2'b00;
  localparam logic [1:0] FWD_RF    = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_EXMEM = 2'b11;

  // Tag records carry the widest supported register number; narrower files zero-extend.
  localparam int unsigned TAG_AW = 8;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [TAG_AW-1:0] dst;
    logic              is_load;
  } tag_rec_t;

  function automatic logic rec_match(
    input tag_rec_t          rec,
    input logic              used,
    input logic [TAG_AW-1:0] src,
    input logic              zero_hw
  );
    return rec.valid && rec.wr && used && (rec.dst == src) &&
           !(zero_hw && (rec.dst == '0));
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Next forwarding select for one source operand, plus its load-use hit flag.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter bit IS_SRC0 = 1'b0,
  parameter bit ZERO_HW = 1'b1
) (
  input  tag_rec_t          ex_rec,
  input  tag_rec_t          mem_rec,
  input  logic [TAG_AW-1:0] src,
  input  logic              used,
  input  logic              swap,
  output logic [1:0]        sel_next,
  output logic              load_hit
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit   = rec_match(ex_rec, used, src, ZERO_HW);
    mem_hit  = rec_match(mem_rec, used, src, ZERO_HW);
    load_hit = ex_hit && ex_rec.is_load;

    // A load in EX cannot forward yet; fall through to the older MEM producer.
    sel_next = FWD_RF;
    if (IS_SRC0 && swap) begin
      sel_next = FWD_SWAP;
    end else if (ex_hit && !ex_rec.is_load) begin
      sel_next = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_next = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select and load-use stall generator with internal EX/MEM tag tracking.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW         = 4,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_STALL     = 1,
  parameter int unsigned ZERO_HARDWIRED = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_wr,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_is_load,
  input  logic                      id_swap,
  input  logic                      ex_flush,
  output logic                      stall,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic [CNT_W-1:0]          stall_cycles
);

  if (NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_num_src
    $error("fwd_hazard_unit: NUM_SRC must be 1..4");
  end
  if (LOAD_STALL < 1 || LOAD_STALL > 2) begin : g_bad_load_stall
    $error("fwd_hazard_unit: LOAD_STALL must be 1..2");
  end
  if (REG_AW > TAG_AW) begin : g_bad_reg_aw
    $error("fwd_hazard_unit: REG_AW exceeds tag record width");
  end

  tag_rec_t             ex_rec_q,  ex_rec_d;
  tag_rec_t             mem_rec_q, mem_rec_d;
  logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d;
  logic                 scnt_q,    scnt_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;

  logic [2*NUM_SRC-1:0] sel_next;
  logic [NUM_SRC-1:0]   load_hit;
  logic                 hz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(
      .IS_SRC0 (i == 0),
      .ZERO_HW (ZERO_HARDWIRED != 0)
    ) u_sel (
      .ex_rec   (ex_rec_q),
      .mem_rec  (mem_rec_q),
      .src      (TAG_AW'(id_src[i*REG_AW +: REG_AW])),
      .used     (id_src_used[i]),
      .swap     (id_swap),
      .sel_next (sel_next[2*i +: 2]),
      .load_hit (load_hit[i])
    );
  end

  always_comb begin
    hz    = id_valid && !id_swap && (|load_hit);
    stall = hz || scnt_q;

    mem_rec_d = ex_rec_q;

    ex_rec_d = '0;
    if (id_valid && !stall && !ex_flush) begin
      ex_rec_d.valid   = 1'b1;
      ex_rec_d.wr      = id_wr;
      ex_rec_d.dst     = TAG_AW'(id_dst);
      ex_rec_d.is_load = id_is_load;
    end

    fwd_sel_d = (stall || ex_flush) ? {NUM_SRC{FWD_RF}} : sel_next;

    // One-bit countdown: only the second bubble of a two-cycle load stall needs remembering.
    scnt_d = 1'b0;
    if (!ex_flush && hz && (LOAD_STALL == 2)) begin
      scnt_d = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rec_q       <= '0;
      mem_rec_q      <= '0;
      fwd_sel_q      <= {NUM_SRC{FWD_RF}};
      scnt_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      ex_rec_q       <= ex_rec_d;
      mem_rec_q      <= mem_rec_d;
      fwd_sel_q      <= fwd_sel_d;
      scnt_q         <= scnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fwd_sel      = fwd_sel_q;
  assign stall_cycles = stall_cycles_q;

  a_swap_no_hz : assert property (@(posedge clk) disable iff (rst)
    (id_swap && !scnt_q) |-> !stall);

  a_bubble_sel : assert property (@(posedge clk) disable iff (rst)
    (stall || ex_flush) |=> (fwd_sel == {NUM_SRC{FWD_RF}}));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Two instances (LOAD_STALL=1/CNT_W=16 and LOAD_STALL=2/CNT_W=4) driven in lockstep.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_wr, id_is_load, id_swap, ex_flush;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic [3:0] id_dst;

  logic        stall1, stall2;
  logic [3:0]  sel1, sel2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_HARDWIRED(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load), .id_swap(id_swap),
    .ex_flush(ex_flush), .stall(stall1), .fwd_sel(sel1), .stall_cycles(cnt1)
  );

  fwd_hazard_unit #(.REG_AW(4), .NUM_SRC(2), .LOAD_STALL(2), .ZERO_HARDWIRED(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load), .id_swap(id_swap),
    .ex_flush(ex_flush), .stall(stall2), .fwd_sel(sel2), .stall_cycles(cnt2)
  );

  // Reference model: the last two instructions that actually issued into EX (age 0 = youngest),
  // how many more bubbles a load-use stall still owes, and the expected registered outputs.
  typedef struct {
    bit v;
    bit wr;
    int dst;
    bit ld;
  } m_ins_t;

  m_ins_t   hist[2][2];
  int       stall_left[2];
  int       exp_cnt[2];
  bit [3:0] exp_sel[2] = '{4'b0101, 4'b0101};
  bit [3:0] nxt_sel[2];
  bit       exp_stall[2];
  bit       hz_m[2];
  int       ls[2]   = '{1, 2};
  int       cmax[2] = '{65535, 15};

  task automatic model_pre();
    for (int k = 0; k < 2; k++) begin
      hz_m[k] = 1'b0;
      for (int s = 0; s < 2; s++) begin
        int       src;
        bit       ex_hit, mem_hit;
        bit [1:0] code;
        src     = (s == 0) ? int'(id_src[3:0]) : int'(id_src[7:4]);
        ex_hit  = hist[k][0].v && hist[k][0].wr && id_src_used[s] && hist[k][0].dst == src && src != 0;
        mem_hit = hist[k][1].v && hist[k][1].wr && id_src_used[s] && hist[k][1].dst == src && src != 0;
        if (id_swap && s == 0)           code = 2'b00;
        else if (ex_hit && !hist[k][0].ld) code = 2'b11;
        else if (mem_hit)                code = 2'b10;
        else                             code = 2'b01;
        nxt_sel[k][2*s +: 2] = code;
        if (ex_hit && hist[k][0].ld && id_valid && !id_swap) hz_m[k] = 1'b1;
      end
      exp_stall[k] = hz_m[k] || (stall_left[k] > 0);
    end
  endtask

  task automatic model_update();
    m_ins_t bub;
    m_ins_t nw;
    bub = '{v: 1'b0, wr: 1'b0, dst: 0, ld: 1'b0};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        hist[k][0] = bub;
        hist[k][1] = bub;
        stall_left[k] = 0;
        exp_cnt[k] = 0;
        exp_sel[k] = 4'b0101;
      end else begin
        exp_sel[k] = (exp_stall[k] || ex_flush) ? 4'b0101 : nxt_sel[k];
        if (ex_flush)              stall_left[k] = 0;
        else if (hz_m[k])          stall_left[k] = ls[k] - 1;
        else if (stall_left[k] > 0) stall_left[k] = stall_left[k] - 1;
        if (exp_stall[k] && exp_cnt[k] < cmax[k]) exp_cnt[k] = exp_cnt[k] + 1;
        hist[k][1] = hist[k][0];
        nw = '{v: 1'b1, wr: id_wr, dst: int'(id_dst), ld: id_is_load};
        hist[k][0] = (exp_stall[k] || ex_flush || !id_valid) ? bub : nw;
      end
    end
  endtask

  task automatic set_in(input bit v, input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] u,
                        input bit w, input bit [3:0] d, input bit ld, input bit sw,
                        input bit fl, input bit r);
    id_valid = v; id_src = {s1, s0}; id_src_used = u; id_wr = w; id_dst = d;
    id_is_load = ld; id_swap = sw; ex_flush = fl; rst = r;
    #1;
    model_pre();
  endtask

  task automatic idle();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    idle();
  endtask

  task automatic test_reset();
    set_in(1, 3, 4, 2'b11, 1, 3, 1, 0, 0, 1);
    tick();
    idle();
    checks++; if (sel1 !== 4'b0101) begin errors++; $display("FAIL reset_sel1: got %b want %b", sel1, 4'b0101); end
    checks++; if (sel2 !== 4'b0101) begin errors++; $display("FAIL reset_sel2: got %b want %b", sel2, 4'b0101); end
    checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
    checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b%b want 00", stall1, stall2); end
  endtask

  task automatic test_exmem();
    do_reset();
    set_in(1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0);   // ADD r3
    tick();
    set_in(1, 5, 3, 2'b11, 1, 6, 0, 0, 0, 0);   // reads r3 on source 1
    checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL exmem_stall: got %b%b want 00", stall1, stall2); end
    tick();
    idle();
    checks++; if (sel1 !== 4'b1101) begin errors++; $display("FAIL exmem_sel1: got %b want %b", sel1, 4'b1101); end
    checks++; if (sel2 !== 4'b1101) begin errors++; $display("FAIL exmem_sel2: got %b want %b", sel2, 4'b1101); end
  endtask

  task automatic test_memwb_priority();
    do_reset();
    set_in(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0);   // writes r5
    tick();
    set_in(1, 1, 2, 2'b11, 1, 6, 0, 0, 0, 0);   // independent
    tick();
    set_in(1, 5, 7, 2'b11, 0, 0, 0, 0, 0, 0);   // reads r5
    tick();
    checks++; if (sel1 !== 4'b0110) begin errors++; $display("FAIL memwb_sel1: got %b want %b", sel1, 4'b0110); end
    set_in(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 2'b00, 1, 5, 0, 0, 0, 0);
    tick();
    set_in(1, 5, 7, 2'b11, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    checks++; if (sel1 !== 4'b0111) begin errors++; $display("FAIL youngest_sel1: got %b want %b", sel1, 4'b0111); end
    checks++; if (sel2 !== 4'b0111) begin errors++; $display("FAIL youngest_sel2: got %b want %b", sel2, 4'b0111); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 1, 0, 2'b01, 1, 2, 1, 0, 0, 0);   // LW r2
    tick();
    set_in(1, 2, 3, 2'b11, 1, 4, 0, 0, 0, 0);   // reads r2, held while stalled
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL lu_stall1_c1: got %b want 1", stall1); end
    checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL lu_stall2_c1: got %b want 1", stall2); end
    tick();
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL lu_stall1_c2: got %b want 0", stall1); end
    checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL lu_stall2_c2: got %b want 1", stall2); end
    checks++; if (sel1 !== 4'b0101) begin errors++; $display("FAIL lu_bubble_sel1: got %b want %b", sel1, 4'b0101); end
    tick();
    checks++; if (sel1 !== 4'b0110) begin errors++; $display("FAIL lu1_sel: got %b want %b", sel1, 4'b0110); end
    checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL lu1_cnt: got %0d want 1", cnt1); end
    checks++; if (stall2 !== 1'b0) begin errors++; $display("FAIL lu_stall2_c3: got %b want 0", stall2); end
    tick();
    idle();
    checks++; if (sel2 !== 4'b0101) begin errors++; $display("FAIL lu2_sel: got %b want %b", sel2, 4'b0101); end
    checks++; if (cnt2 !== 4'd2) begin errors++; $display("FAIL lu2_cnt: got %0d want 2", cnt2); end
    checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL lu1_cnt_final: got %0d want 1", cnt1); end
  endtask

  task automatic test_zero_swap();
    do_reset();
    set_in(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);   // writes r0
    tick();
    set_in(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);   // reads r0
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall1); end
    tick();
    checks++; if (sel1 !== 4'b0101) begin errors++; $display("FAIL zero_sel: got %b want %b", sel1, 4'b0101); end
    set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0);   // LW r2
    tick();
    set_in(1, 2, 2, 2'b11, 1, 7, 0, 1, 0, 0);   // swap, both sources r2
    checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL swap_stall: got %b%b want 00", stall1, stall2); end
    tick();
    idle();
    checks++; if (sel1 !== 4'b0100) begin errors++; $display("FAIL swap_sel1: got %b want %b", sel1, 4'b0100); end
    checks++; if (sel2 !== 4'b0100) begin errors++; $display("FAIL swap_sel2: got %b want %b", sel2, 4'b0100); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0);
    tick();
    set_in(1, 2, 3, 2'b11, 1, 4, 0, 0, 1, 0);   // load-use with flush
    checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b want 1", stall2); end
    tick();
    set_in(1, 2, 3, 2'b11, 1, 4, 0, 0, 0, 0);
    checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b%b want 00", stall1, stall2); end
    checks++; if (sel1 !== 4'b0101 || sel2 !== 4'b0101) begin errors++; $display("FAIL flush_sel: got %b/%b want 0101", sel1, sel2); end
    checks++; if (cnt2 !== 4'd1) begin errors++; $display("FAIL flush_cnt2: got %0d want 1", cnt2); end
    tick();
    idle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0);
    tick();
    set_in(1, 2, 3, 2'b11, 1, 4, 0, 0, 0, 1);   // stalling, reset pulsed
    tick();
    set_in(1, 2, 3, 2'b11, 1, 4, 0, 0, 0, 0);
    checks++; if (stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b%b want 00", stall1, stall2); end
    checks++; if (sel1 !== 4'b0101 || sel2 !== 4'b0101) begin errors++; $display("FAIL rstmid_sel: got %b/%b want 0101", sel1, sel2); end
    checks++; if (cnt1 !== 16'd0 || cnt2 !== 4'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", cnt1, cnt2); end
    tick();
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      set_in(1, 0, 0, 2'b00, 1, 2, 1, 0, 0, 0);
      tick();
      set_in(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      tick();
      tick();
    end
    checks++; if (cnt1 !== 16'd20) begin errors++; $display("FAIL sat_cnt1: got %0d want 20", cnt1); end
    checks++; if (cnt2 !== 4'd15) begin errors++; $display("FAIL sat_cnt2: got %0d want 15", cnt2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(3, 0) != 0, 4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
             2'($urandom), 1'($urandom), 4'($urandom_range(3, 0)), $urandom_range(2, 0) == 0,
             $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0, $urandom_range(99, 0) == 0);
      checks++; if (stall1 !== exp_stall[0]) begin errors++; $display("FAIL rnd_stall1 @%0d: got %b want %b", n, stall1, exp_stall[0]); end
      checks++; if (stall2 !== exp_stall[1]) begin errors++; $display("FAIL rnd_stall2 @%0d: got %b want %b", n, stall2, exp_stall[1]); end
      tick();
      checks++; if (sel1 !== exp_sel[0]) begin errors++; $display("FAIL rnd_sel1 @%0d: got %b want %b", n, sel1, exp_sel[0]); end
      checks++; if (sel2 !== exp_sel[1]) begin errors++; $display("FAIL rnd_sel2 @%0d: got %b want %b", n, sel2, exp_sel[1]); end
      checks++; if (cnt1 !== 16'(exp_cnt[0])) begin errors++; $display("FAIL rnd_cnt1 @%0d: got %0d want %0d", n, cnt1, exp_cnt[0]); end
      checks++; if (cnt2 !== 4'(exp_cnt[1])) begin errors++; $display("FAIL rnd_cnt2 @%0d: got %0d want %0d", n, cnt2, exp_cnt[1]); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_exmem();
    test_memwb_priority();
    test_load_use();
    test_zero_swap();
    test_flush();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
